// File: rtl/uart_pkg.sv
// Shared UART definitions: default geometry, receiver/transmitter FSM states
// and small line-level helpers.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DIV_WIDTH  = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // A start bit begins with a high-to-low transition of the line.
  function automatic logic start_edge(input logic prev_level, input logic cur_level);
    return prev_level & ~cur_level;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line plus received-byte delivery signals of the UART receiver.
// master: the receiver (samples rx, drives the delivery signals).
// slave : the line driver / downstream consumer side.
interface uart_receiver_if import uart_pkg::*; #(
  parameter int DATA_BITS = UART_DATA_BITS
) ();

  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  busy
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Restartable oversample tick generator. Counts 0..div-1 and flags tick on
// the last count; div of 0 or 1 gives a tick every cycle. clear restarts the
// count so the sampling phase lines up with the start edge.
module uart_tick_gen import uart_pkg::*; #(
  parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
  input  logic                 main_clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] last_s;

  // Terminal count; 0 and 1 both collapse to a one-cycle period.
  always_comb begin
    last_s = {DIV_WIDTH{1'b0}};
    if (div <= DIV_WIDTH'(1)) begin
      last_s = {DIV_WIDTH{1'b0}};
    end else begin
      last_s = div - DIV_WIDTH'(1);
    end
  end

  // Tick counter; >= makes the wrap safe even if div shrinks below the count.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (cnt_r >= last_s) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else begin
      cnt_r <= cnt_r + DIV_WIDTH'(1);
    end
  end

  assign tick = (cnt_r >= last_s) & ~clear;

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver. rx is synchronized, a falling edge starts a frame,
// the start bit is re-checked at its midpoint, data bits are sampled at their
// midpoints LSB first and the stop bit decides between data_valid and
// frame_error. The divisor is captured at frame start.
module uart_receiver import uart_pkg::*; #(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                 main_clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  uart_receiver_if.master      bus
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BITS - 1);

  // Input path: two-flop synchronizer plus one delay flop for edge detect.
  logic rx_meta_r;
  logic rx_sync_r;
  logic rx_dly_r;
  logic start_edge_s;

  uart_state_t          state_r,       state_nxt;
  logic [DIV_WIDTH-1:0] div_r,         div_nxt;
  logic [OS_W-1:0]      os_cnt_r,      os_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt_r,     bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_r,       shift_nxt;
  logic [DATA_BITS-1:0] data_out_r,    data_out_nxt;
  logic                 data_valid_r,  data_valid_nxt;
  logic                 frame_error_r, frame_error_nxt;
  logic                 busy_r;
  logic                 clear_s;
  logic                 tick_s;

  // Bring the asynchronous line into the main_clk domain; idle level is high.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_dly_r  <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rx_sync_r <= rx_meta_r;
      rx_dly_r  <= rx_sync_r;
    end
  end

  assign start_edge_s = start_edge(rx_dly_r, rx_sync_r);

  uart_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .main_clk (main_clk),
    .reset    (reset),
    .clear    (clear_s),
    .div      (div_r),
    .tick     (tick_s)
  );

  // Next-state and datapath decisions for the receive FSM.
  always_comb begin
    state_nxt       = state_r;
    div_nxt         = div_r;
    os_cnt_nxt      = os_cnt_r;
    bit_cnt_nxt     = bit_cnt_r;
    shift_nxt       = shift_r;
    data_out_nxt    = data_out_r;
    data_valid_nxt  = 1'b0;
    frame_error_nxt = 1'b0;
    clear_s         = 1'b0;

    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          state_nxt   = START;
          div_nxt     = baud_div;
          clear_s     = 1'b1;
          os_cnt_nxt  = {OS_W{1'b0}};
          bit_cnt_nxt = {BIT_W{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end

      START: begin
        if (tick_s) begin
          if (os_cnt_r == OS_HALF_LAST) begin
            os_cnt_nxt = {OS_W{1'b0}};
            if (rx_sync_r == 1'b0) begin
              state_nxt = DATA;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_nxt = IDLE;
            end
          end else begin
            os_cnt_nxt = os_cnt_r + OS_W'(1);
          end
        end else begin
          os_cnt_nxt = os_cnt_r;
        end
      end

      DATA: begin
        if (tick_s) begin
          if (os_cnt_r == OS_LAST) begin
            os_cnt_nxt = {OS_W{1'b0}};
            shift_nxt  = {rx_sync_r, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_nxt = {BIT_W{1'b0}};
              state_nxt   = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt_r + BIT_W'(1);
            end
          end else begin
            os_cnt_nxt = os_cnt_r + OS_W'(1);
          end
        end else begin
          os_cnt_nxt = os_cnt_r;
        end
      end

      STOP: begin
        if (tick_s) begin
          if (os_cnt_r == OS_LAST) begin
            os_cnt_nxt = {OS_W{1'b0}};
            state_nxt  = IDLE;
            if (rx_sync_r == 1'b1) begin
              data_out_nxt   = shift_r;
              data_valid_nxt = 1'b1;
            end else begin
              frame_error_nxt = 1'b1;
            end
          end else begin
            os_cnt_nxt = os_cnt_r + OS_W'(1);
          end
        end else begin
          os_cnt_nxt = os_cnt_r;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_r       <= IDLE;
      div_r         <= {DIV_WIDTH{1'b0}};
      os_cnt_r      <= {OS_W{1'b0}};
      bit_cnt_r     <= {BIT_W{1'b0}};
      shift_r       <= {DATA_BITS{1'b0}};
      data_out_r    <= {DATA_BITS{1'b0}};
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      div_r         <= div_nxt;
      os_cnt_r      <= os_cnt_nxt;
      bit_cnt_r     <= bit_cnt_nxt;
      shift_r       <= shift_nxt;
      data_out_r    <= data_out_nxt;
      data_valid_r  <= data_valid_nxt;
      frame_error_r <= frame_error_nxt;
      busy_r        <= (state_nxt != IDLE);
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.frame_error = frame_error_r;
  assign bus.busy        = busy_r;

endmodule
